// File: rtl/flght_pkg.sv
// Shared constants for the PD flight controller: FSM encodings, motor
// speed constants, saturation limits and the output clamp helper.
package flght_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PTCH = 3'd1;
  localparam logic [2:0] ST_ROLL = 3'd2;
  localparam logic [2:0] ST_YAW  = 3'd3;
  localparam logic [2:0] ST_MIX  = 3'd4;

  localparam logic [10:0] MIN_RUN_SPEED = 11'd416;
  localparam logic [10:0] CAL_SPEED     = 11'h1B0;

  localparam int ERR_SAT_MAX = 511;
  localparam int ERR_SAT_MIN = -512;
  localparam int DD_SAT_MAX  = 63;
  localparam int DD_SAT_MIN  = -64;

  // Width of P/D terms and mixer sums; wide enough for every worst-case sum.
  localparam int TERM_W = 13;

  function automatic logic [10:0] clamp_speed(input logic signed [TERM_W-1:0] v);
    if (v < 0)
      clamp_speed = 11'd0;
    else if (v > 13'sd2047)
      clamp_speed = 11'd2047;
    else
      clamp_speed = v[10:0];
  endfunction

endpackage

// File: rtl/flght_cntrl_pd_math.sv
// Combinational PD datapath, time-shared across pitch, roll and yaw.
// Produces the saturated error (for the history queue) and both gain terms.
module flght_cntrl_pd_math
  import flght_pkg::*;
#(
  parameter int P_COEFF = 5,
  parameter int D_COEFF = 9
) (
  input  logic signed [15:0]       actual,
  input  logic signed [15:0]       desired,
  input  logic signed [9:0]        prev,
  output logic signed [9:0]        err_sat,
  output logic signed [TERM_W-1:0] p_term,
  output logic signed [TERM_W-1:0] d_term
);

  logic signed [16:0] err;
  logic signed [10:0] ddiff;
  logic signed [6:0]  dsat;
  logic signed [15:0] p_prod;
  logic signed [15:0] p_shift;
  logic signed [15:0] d_prod;

  always_comb begin
    err = {actual[15], actual} - {desired[15], desired};
    if (err > 17'(ERR_SAT_MAX))
      err_sat = 10'(ERR_SAT_MAX);
    else if (err < 17'(ERR_SAT_MIN))
      err_sat = 10'(ERR_SAT_MIN);
    else
      err_sat = err[9:0];

    ddiff = {err_sat[9], err_sat} - {prev[9], prev};
    if (ddiff > 11'(DD_SAT_MAX))
      dsat = 7'(DD_SAT_MAX);
    else if (ddiff < 11'(DD_SAT_MIN))
      dsat = 7'(DD_SAT_MIN);
    else
      dsat = ddiff[6:0];

    p_prod  = $signed({{6{err_sat[9]}}, err_sat}) * $signed(16'(P_COEFF));
    p_shift = p_prod >>> 3;
    p_term  = p_shift[TERM_W-1:0];
    d_prod  = $signed({{9{dsat[6]}}, dsat}) * $signed(16'(D_COEFF));
    d_term  = d_prod[TERM_W-1:0];
  end

endmodule

// File: rtl/flght_cntrl.sv
// PD flight controller: latches attitude on vld, runs one PD axis per cycle
// through a shared datapath, then mixes into four registered motor speeds.
module flght_cntrl
  import flght_pkg::*;
#(
  parameter int D_QUEUE_DEPTH = 12,
  parameter int P_COEFF       = 5,
  parameter int D_COEFF       = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic               inertial_cal,
  input  logic signed [15:0] ptch,
  input  logic signed [15:0] roll,
  input  logic signed [15:0] yaw,
  input  logic signed [15:0] d_ptch,
  input  logic signed [15:0] d_roll,
  input  logic signed [15:0] d_yaw,
  input  logic [8:0]         thrst,
  output logic [10:0]        frnt_spd,
  output logic [10:0]        bck_spd,
  output logic [10:0]        lft_spd,
  output logic [10:0]        rght_spd,
  output logic               upd_vld,
  output logic [2:0]         dbg_state
);

  // Handshake: vld is a one-cycle strobe accepted only in IDLE with
  // inertial_cal high; upd_vld is a one-cycle pulse with the new speeds.

  localparam int PTR_W = (D_QUEUE_DEPTH > 1) ? $clog2(D_QUEUE_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(D_QUEUE_DEPTH - 1);

  logic [2:0] state;
  logic signed [15:0] ptch_q, roll_q, yaw_q, d_ptch_q, d_roll_q, d_yaw_q;
  logic [8:0] thrst_q;

  logic signed [9:0] q_p [D_QUEUE_DEPTH];
  logic signed [9:0] q_r [D_QUEUE_DEPTH];
  logic signed [9:0] q_y [D_QUEUE_DEPTH];
  logic [PTR_W-1:0]  ptr_p, ptr_r, ptr_y;

  logic signed [TERM_W-1:0] p_p, p_d, r_p, r_d, y_p, y_d;

  logic signed [15:0]       mux_act, mux_des;
  logic signed [9:0]        mux_prev;
  logic signed [9:0]        err_sat;
  logic signed [TERM_W-1:0] p_term, d_term;

  logic signed [TERM_W-1:0] base, sum_f, sum_b, sum_l, sum_r;

  assign dbg_state = state;

  always_comb begin
    mux_act  = '0;
    mux_des  = '0;
    mux_prev = '0;
    case (state)
      ST_PTCH: begin mux_act = ptch_q; mux_des = d_ptch_q; mux_prev = q_p[ptr_p]; end
      ST_ROLL: begin mux_act = roll_q; mux_des = d_roll_q; mux_prev = q_r[ptr_r]; end
      ST_YAW:  begin mux_act = yaw_q;  mux_des = d_yaw_q;  mux_prev = q_y[ptr_y]; end
      default: ;
    endcase
  end

  flght_cntrl_pd_math #(.P_COEFF(P_COEFF), .D_COEFF(D_COEFF)) u_pd (
    .actual  (mux_act),
    .desired (mux_des),
    .prev    (mux_prev),
    .err_sat (err_sat),
    .p_term  (p_term),
    .d_term  (d_term)
  );

  always_comb begin
    base  = TERM_W'(MIN_RUN_SPEED) + TERM_W'(thrst_q);
    sum_f = base - p_p - p_d - y_p - y_d;
    sum_b = base + p_p + p_d - y_p - y_d;
    sum_l = base - r_p - r_d + y_p + y_d;
    sum_r = base + r_p + r_d + y_p + y_d;
  end

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    ptr_next = (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptch_q   <= '0; roll_q   <= '0; yaw_q   <= '0;
      d_ptch_q <= '0; d_roll_q <= '0; d_yaw_q <= '0;
      thrst_q  <= '0;
      ptr_p    <= '0; ptr_r    <= '0; ptr_y   <= '0;
      p_p <= '0; p_d <= '0; r_p <= '0; r_d <= '0; y_p <= '0; y_d <= '0;
      for (int i = 0; i < D_QUEUE_DEPTH; i++) begin
        q_p[i] <= '0;
        q_r[i] <= '0;
        q_y[i] <= '0;
      end
      frnt_spd <= '0; bck_spd <= '0; lft_spd <= '0; rght_spd <= '0;
      upd_vld  <= 1'b0;
    end else begin
      upd_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (vld && inertial_cal) begin
            ptch_q   <= ptch;   roll_q   <= roll;   yaw_q   <= yaw;
            d_ptch_q <= d_ptch; d_roll_q <= d_roll; d_yaw_q <= d_yaw;
            thrst_q  <= thrst;
            state    <= ST_PTCH;
          end
        end
        ST_PTCH: begin
          p_p <= p_term; p_d <= d_term;
          q_p[ptr_p] <= err_sat;
          ptr_p <= ptr_next(ptr_p);
          state <= ST_ROLL;
        end
        ST_ROLL: begin
          r_p <= p_term; r_d <= d_term;
          q_r[ptr_r] <= err_sat;
          ptr_r <= ptr_next(ptr_r);
          state <= ST_YAW;
        end
        ST_YAW: begin
          y_p <= p_term; y_d <= d_term;
          q_y[ptr_y] <= err_sat;
          ptr_y <= ptr_next(ptr_y);
          state <= ST_MIX;
        end
        ST_MIX: begin
          if (inertial_cal) begin
            frnt_spd <= clamp_speed(sum_f);
            bck_spd  <= clamp_speed(sum_b);
            lft_spd  <= clamp_speed(sum_l);
            rght_spd <= clamp_speed(sum_r);
            upd_vld  <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      // Uncalibrated sensors: hold motors at the calibration speed.
      if (!inertial_cal) begin
        frnt_spd <= CAL_SPEED; bck_spd <= CAL_SPEED;
        lft_spd  <= CAL_SPEED; rght_spd <= CAL_SPEED;
      end
    end
  end

endmodule
